// File: rtl/reg_scoreboard.sv
// Purpose : per-register pending-write scoreboard for the ID-stage RAW hazard check.
//           It counts writes issued in ID that have not yet retired in WB.
// Latency : an issue makes its register busy on the next cycle. A write-back releases
//           busy in the same cycle through a bypass, and the state itself clears on the next cycle.
// Backpr. : issue_ready drops when the destination counter is saturated (unless the same
//           register also retires this cycle) or when the total counter is all-ones.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   issue_valid/waddr/is_load        register-writing instruction issued from ID
//   issue_ready                      the issue is accepted this cycle (combinational)
//   wb_valid/wb_waddr                one register write retired in WB
//   flush                            drop all pending state (underflow_err is kept)
//   rs1/rs2 _en/_addr                source operands read in ID
//   rs1_busy/rs2_busy                source has an unretired pending write
//   rs_load_hit                      a busy enabled source is pending on a load
//   stall                            ID must hold
//   outstanding                      total pending writes
//   underflow_err                    sticky: write-back arrived with no pending write
module reg_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 2,
  parameter int TOT_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_waddr,
  input  logic                      issue_is_load,
  output logic                      issue_ready,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  input  logic                      flush,
  input  logic                      rs1_en,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic                      rs2_en,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rs_load_hit,
  output logic                      stall,
  output logic [TOT_WIDTH-1:0]      outstanding,
  output logic                      underflow_err
);

  localparam int NREG = 2 ** REG_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [TOT_WIDTH-1:0] TOT_MAX = {TOT_WIDTH{1'b1}};
  localparam logic [TOT_WIDTH-1:0] TOT_ONE = TOT_WIDTH'(1);

  // State
  logic [CNT_WIDTH-1:0] cnt_q  [NREG];
  logic [CNT_WIDTH-1:0] cnt_d  [NREG];
  logic                 load_q [NREG];
  logic                 load_d [NREG];
  logic [TOT_WIDTH-1:0] out_q, out_d;
  logic                 uf_q, uf_d;

  // Decoded events
  logic issue_nz, wb_nz;
  logic wb_same_reg;
  logic issue_acc;
  logic do_inc, do_dec, do_uf;

  assign issue_nz    = (issue_waddr != '0);
  assign wb_nz       = (wb_waddr != '0);
  assign wb_same_reg = wb_valid && (wb_waddr == issue_waddr);

  // A saturated counter can still take an issue when the same register retires in the
  // same cycle, because the net count does not change.
  always_comb begin
    issue_ready = 1'b1;
    if ((cnt_q[issue_waddr] == CNT_MAX) && !wb_same_reg) issue_ready = 1'b0;
    if (out_q == TOT_MAX)                                 issue_ready = 1'b0;
  end

  assign issue_acc = issue_valid && issue_ready;
  // x0 is never tracked, so issues and write-backs to it are accepted and ignored.
  assign do_inc    = issue_acc && issue_nz;
  assign do_dec    = wb_valid && wb_nz && (cnt_q[wb_waddr] != '0);
  assign do_uf     = wb_valid && wb_nz && (cnt_q[wb_waddr] == '0);

  // Next-state logic
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i]  = cnt_q[i];
      load_d[i] = load_q[i];
    end
    out_d = out_q;
    uf_d  = uf_q;

    if (flush) begin
      // A flush wins over any issue or write-back presented in the same cycle.
      for (int i = 0; i < NREG; i++) begin
        cnt_d[i]  = '0;
        load_d[i] = 1'b0;
      end
      out_d = '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        logic inc_i, dec_i;
        inc_i = do_inc && (issue_waddr == REG_ADDR_WIDTH'(i));
        dec_i = do_dec && (wb_waddr == REG_ADDR_WIDTH'(i));
        if (inc_i && !dec_i) cnt_d[i] = cnt_q[i] + CNT_ONE;
        if (dec_i && !inc_i) cnt_d[i] = cnt_q[i] - CNT_ONE;
        // The latest issue sets the load flag. A retire that empties the register clears it.
        if (inc_i)                             load_d[i] = issue_is_load;
        else if (dec_i && cnt_q[i] == CNT_ONE) load_d[i] = 1'b0;
      end
      case ({do_inc, do_dec})
        2'b10:   out_d = out_q + TOT_ONE;
        2'b01:   out_d = out_q - TOT_ONE;
        default: out_d = out_q;
      endcase
      if (do_uf) uf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i]  <= '0;
        load_q[i] <= 1'b0;
      end
      out_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i]  <= cnt_d[i];
        load_q[i] <= load_d[i];
      end
      out_q <= out_d;
      uf_q  <= uf_d;
    end
  end

  // Source hazard check. A pending count of one that retires this cycle is released
  // right away, so ID does not lose a cycle waiting for the register file update.
  always_comb begin
    rs1_busy = rs1_en && (rs1_addr != '0) && (cnt_q[rs1_addr] != '0) &&
               !(wb_valid && (wb_waddr == rs1_addr) && (cnt_q[rs1_addr] == CNT_ONE));
    rs2_busy = rs2_en && (rs2_addr != '0) && (cnt_q[rs2_addr] != '0) &&
               !(wb_valid && (wb_waddr == rs2_addr) && (cnt_q[rs2_addr] == CNT_ONE));
  end

  assign rs_load_hit   = (rs1_busy && load_q[rs1_addr]) || (rs2_busy && load_q[rs2_addr]);
  assign stall         = !rst && (rs1_busy || rs2_busy || (issue_valid && !issue_ready));
  assign outstanding   = out_q;
  assign underflow_err = uf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Purpose : directed self-checking bench for reg_scoreboard.
// Latency : inputs are driven 1ns after posedge. Outputs are sampled 1ns later, before the next edge.
// Backpr. : covers per-register saturation, the total counter saturating at all-ones, and flush.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_is_load, issue_ready;
  logic [4:0] issue_waddr;
  logic       wb_valid;
  logic [4:0] wb_waddr;
  logic       flush;
  logic       rs1_en, rs2_en;
  logic [4:0] rs1_addr, rs2_addr;
  logic       rs1_busy, rs2_busy, rs_load_hit, stall;
  logic [5:0] outstanding;
  logic       underflow_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2), .TOT_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr), .issue_is_load(issue_is_load),
    .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_waddr(wb_waddr), .flush(flush),
    .rs1_en(rs1_en), .rs1_addr(rs1_addr), .rs2_en(rs2_en), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs_load_hit(rs_load_hit), .stall(stall),
    .outstanding(outstanding), .underflow_err(underflow_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock. Leave 1ns after the edge before driving the next inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle after a change in inputs.
  task automatic settle();
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_waddr = 0; issue_is_load = 0;
    wb_valid = 0; wb_waddr = 0; flush = 0;
    rs1_en = 0; rs1_addr = 0; rs2_en = 0; rs2_addr = 0;
  endtask

  task automatic issue(input int r, input bit ld);
    issue_valid = 1; issue_waddr = 5'(r); issue_is_load = ld;
  endtask

  task automatic wb(input int r);
    wb_valid = 1; wb_waddr = 5'(r);
  endtask

  initial begin
    idle();
    rst = 1;
    issue(5, 0);
    rs1_en = 1;
    settle();
    check("stall_in_reset", stall, 0);
    cyc(); cyc();
    rst = 0;
    idle();
    settle();
    check("reset_outstanding", outstanding, 0);
    check("reset_underflow", underflow_err, 0);
    check("reset_ready", issue_ready, 1);
    check("reset_stall", stall, 0);

    // Basic RAW hazard on x5, then release through the write-back bypass.
    issue(5, 0);
    cyc();
    idle(); rs1_en = 1; rs1_addr = 5; settle();
    check("x5_busy", rs1_busy, 1);
    check("x5_stall", stall, 1);
    check("x5_outstanding", outstanding, 1);
    cyc();
    wb(5); settle();
    check("x5_bypass_busy", rs1_busy, 0);
    check("x5_bypass_stall", stall, 0);
    cyc();
    wb_valid = 0; settle();
    check("x5_outstanding_after_wb", outstanding, 0);
    check("x5_busy_after_wb", rs1_busy, 0);

    // Saturate x7 (max three pending writes).
    idle();
    for (int k = 0; k < 3; k++) begin issue(7, 0); cyc(); end
    settle();
    check("x7_ready_full", issue_ready, 0);
    check("x7_stall_full", stall, 1);
    cyc();
    idle(); settle();
    check("x7_rejected_outstanding", outstanding, 3);
    issue(7, 0); wb(7); settle();
    check("x7_ready_with_wb", issue_ready, 1);
    cyc();
    idle(); rs1_en = 1; rs1_addr = 7; settle();
    check("x7_net_zero_outstanding", outstanding, 3);
    // Draining must take three write-backs if the count stayed at three.
    wb(7); cyc(); wb(7); cyc();
    wb_valid = 0; settle();
    check("x7_busy_after_two_wb", rs1_busy, 1);
    wb(7); settle();
    check("x7_bypass_last", rs1_busy, 0);
    cyc();
    idle(); settle();
    check("x7_drained", outstanding, 0);

    // Load flag: the latest issue wins.
    issue(3, 1); cyc();
    idle(); rs2_en = 1; rs2_addr = 3; settle();
    check("x3_load_hit", rs_load_hit, 1);
    check("x3_busy_load", rs2_busy, 1);
    issue(3, 0); cyc();
    issue_valid = 0; settle();
    check("x3_load_hit_cleared", rs_load_hit, 0);
    check("x3_busy_nonload", rs2_busy, 1);
    check("x3_outstanding", outstanding, 2);
    wb(3); cyc();
    wb_valid = 0; settle();
    check("x3_busy_one_left", rs2_busy, 1);
    wb(3); cyc();
    wb_valid = 0; settle();
    check("x3_released", rs2_busy, 0);
    check("x3_outstanding_zero", outstanding, 0);

    // x0 is never tracked.
    idle(); issue(0, 1); wb(0); rs1_en = 1; rs1_addr = 0; settle();
    check("x0_ready", issue_ready, 1);
    cyc();
    wb_valid = 0; settle();
    check("x0_busy", rs1_busy, 0);
    check("x0_outstanding", outstanding, 0);
    check("x0_no_underflow", underflow_err, 0);

    // Write-back underflow on x9.
    idle(); wb(9); cyc();
    idle(); settle();
    check("x9_underflow", underflow_err, 1);
    check("x9_outstanding", outstanding, 0);

    // Flush drops pending writes and wins over a same-cycle issue.
    issue(1, 0); cyc(); issue(2, 0); cyc(); issue(4, 1); cyc();
    idle(); settle();
    check("pre_flush_outstanding", outstanding, 3);
    flush = 1; issue(6, 0); cyc();
    idle(); rs1_en = 1; rs1_addr = 1; rs2_en = 1; rs2_addr = 6; settle();
    check("flush_busy_x1", rs1_busy, 0);
    check("flush_x6_untracked", rs2_busy, 0);
    check("flush_outstanding", outstanding, 0);
    check("flush_keeps_underflow", underflow_err, 1);
    rs1_addr = 4; settle();
    check("flush_busy_x4", rs1_busy, 0);

    // The total counter saturates at all-ones. Use x1..x21 three times each, giving 63.
    idle();
    for (int r = 1; r <= 21; r++)
      for (int k = 0; k < 3; k++) begin issue(r, 0); cyc(); end
    idle(); settle();
    check("total_full", outstanding, 63);
    issue(22, 0); settle();
    check("total_full_ready", issue_ready, 0);
    cyc();
    idle(); rs1_en = 1; rs1_addr = 22; settle();
    check("total_full_rejected", rs1_busy, 0);
    check("total_full_hold", outstanding, 63);
    wb(21); issue(22, 0); settle();
    check("total_full_wb_ready", issue_ready, 0);
    cyc();
    idle(); settle();
    check("total_after_wb", outstanding, 62);

    // Only reset clears the sticky error.
    flush = 1; cyc(); idle(); settle();
    check("flush_after_total", outstanding, 0);
    check("underflow_still_set", underflow_err, 1);
    rst = 1; cyc(); rst = 0; settle();
    check("rst_clears_underflow", underflow_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer side of the ID-stage RAW hazard check. It tracks register writes that are in flight between issue (ID) and write-back (WB).
- For each architectural register it keeps a pending-write counter. ID source operands are checked against these counters, and the block returns busy/stall.
- Write-back retires entries. A pipeline flush clears all state.

Parameters:
- REG_ADDR_WIDTH, 5, register address width; 2**REG_ADDR_WIDTH registers tracked.
- CNT_WIDTH, 2, width of each per-register pending counter; max in-flight writes per register = 2**CNT_WIDTH-1.
- TOT_WIDTH, 6, width of the total outstanding-write counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- issue_valid  input  1  ID issues an instruction that writes a register.
- issue_waddr  input  REG_ADDR_WIDTH  destination register of the issued instruction.
- issue_is_load  input  1  issued instruction is a load; sets that register's load flag.
- issue_ready  output  1  scoreboard can accept the issue this cycle.
- wb_valid  input  1  WB retires one register write.
- wb_waddr  input  REG_ADDR_WIDTH  register written back.
- flush  input  1  pipeline flush; discards all pending state.
- rs1_en, rs2_en  input  1 each  source operand is actually read.
- rs1_addr, rs2_addr  input  REG_ADDR_WIDTH each  source register addresses in ID.
- rs1_busy, rs2_busy  output  1 each  source register has an unretired pending write.
- rs_load_hit  output  1  an enabled busy source is pending on a load.
- stall  output  1  ID must hold.
- outstanding  output  TOT_WIDTH  total pending writes.
- underflow_err  output  1  sticky error flag.

Behaviour:
- All state updates on posedge clk. rst is synchronous. Reset clears every counter, every load flag, outstanding and underflow_err to 0.
- Register 0 is never tracked:
  - issue or wb to x0 is accepted with no state change;
  - rs*_busy for x0 is always 0.
- issue_ready is combinational:
  - 0 when cnt[issue_waddr] == MAX and no same-cycle wb to the same register;
  - 0 when outstanding is all-ones;
  - 1 otherwise.
- Issue is accepted only when issue_valid & issue_ready. An unaccepted issue causes no state change.
- Accepted issue: cnt[waddr] +1, and load flag[waddr] <= issue_is_load (the latest issue wins).
- wb_valid:
  - if cnt[wb_waddr] != 0: cnt[wb_waddr] -1;
  - when the counter reaches 0, the load flag is cleared.
- wb to a register whose cnt is 0: no change, and underflow_err is set (sticky until rst).
- Same-cycle accepted issue and wb to the same register: count is unchanged; load flag takes the issue value.
- outstanding = +1 per accepted non-x0 issue, -1 per valid non-underflow non-x0 wb. It is net 0 when both happen.
- flush has priority over issue and wb in the same cycle. Next cycle all counters, load flags and outstanding are 0; underflow_err is kept.
- rsN_busy (combinational) = rsN_en & rsN_addr != 0 & cnt[rsN_addr] != 0 & !(wb_valid & wb_waddr == rsN_addr & cnt[rsN_addr] == 1). This is a same-cycle write-back release bypass.
- rs_load_hit = (rs1_busy & load flag[rs1_addr]) | (rs2_busy & load flag[rs2_addr]).
- stall = rs1_busy | rs2_busy | (issue_valid & !issue_ready). stall is 0 during the rst cycle.
- Latency:
  - issue → busy visible: next cycle;
  - wb → busy release: same cycle via bypass, state cleared next cycle.

Test Plan:
- After rst, issue x5 at cycle 1 (issue_is_load=0), then rs1_addr=5, rs1_en=1 at cycle 2 → rs1_busy=1, stall=1, outstanding=1. wb x5 at cycle 4 → rs1_busy=0 that same cycle, outstanding=0 at cycle 5.
- Issue x7 three times with CNT_WIDTH=2 (cnt=3), then issue x7 again → issue_ready=0, stall=1, cnt stays 3. Repeat the 4th issue with a same-cycle wb x7 → accepted, cnt stays 3.
- Issue x3 as a load, rs2_addr=3, rs2_en=1 → rs_load_hit=1. Issue x3 non-load → rs_load_hit=0, busy stays 1. Two wb of x3 → busy=0.
- Issue x0 and wb x0; rs1_addr=0 → outstanding=0, rs1_busy=0, underflow_err=0.
- wb x9 with cnt=0 → underflow_err=1, and it stays 1 through a flush. Only rst clears it.
- Pending writes on x1, x2, x4 (outstanding=3); flush together with issue x6 → next cycle all busy=0, outstanding=0, x6 not tracked.
